// File: rtl/mem_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wr_ctrl
//  Description : Skewed write controller for the accumulator memory banks.
//                One bank per systolic column; column j runs one cycle behind
//                column j-1, so each column's enable/address is delayed by j
//                cycles and every row lands at the same address in each bank.
//  Ports       : clk, rstn      - clock, synchronous active-low reset
//                wr_start       - start pulse, honoured only while idle
//                num_row        - rows to write (clamped to ACCUM_ROW)
//                base_addr      - first bank address (wraps modulo 2^ADDR_WIDTH)
//                acc_mode       - 1 = accumulate, 0 = overwrite
//                wr_en_out      - per-bank write enable (bit j = column j)
//                wr_addr        - per-bank write address
//                wr_acc         - per-bank accumulate qualifier
//                busy, done     - operation in progress / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wr_ctrl #(
  parameter  int SYS_ROW     = 16,
  parameter  int SYS_COL     = 16,
  parameter  int DATA_WIDTH  = 16,
  parameter  int ACCUM_SIZE  = 4096,
  parameter  int START_DELAY = 2,
  localparam int ACCUM_ROW   = ACCUM_SIZE / SYS_COL,
  localparam int ADDR_WIDTH  = $clog2(ACCUM_ROW)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_start,
  input  logic [DATA_WIDTH-1:0] num_row,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  acc_mode,
  output logic [SYS_COL-1:0]    wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr [0:SYS_COL-1],
  output logic [SYS_COL-1:0]    wr_acc,
  output logic                  busy,
  output logic                  done
);

  // One shared down-counter serves WAIT, ISSUE and DRAIN; size it for the
  // largest of the three phase lengths.
  localparam int CNT_MAX_A = (ACCUM_ROW > START_DELAY) ? ACCUM_ROW : START_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > SYS_COL) ? CNT_MAX_A : SYS_COL;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int CMP_W     = ((DATA_WIDTH > CNT_W) ? DATA_WIDTH : CNT_W) + 1;

  localparam logic [CNT_W-1:0] D_M1     = CNT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] DRAIN_M1 = CNT_W'((SYS_COL > 1) ? SYS_COL - 2 : 0);
  localparam logic [CNT_W-1:0] ROW_MAX  = CNT_W'(ACCUM_ROW);
  localparam logic [CMP_W-1:0] ROW_EXT  = CMP_W'(ACCUM_ROW);

  // Elaboration-time sanity checks on the array geometry.
  generate
    if (SYS_ROW < 1 || SYS_COL < 1) begin : g_bad_geometry
      $error("mem_wr_ctrl: SYS_ROW and SYS_COL must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      n_lat;
  logic [ADDR_WIDTH-1:0] base_lat;
  logic                  mode_lat;

  // Column-0 write lane, driven straight from the FSM.
  logic                  en0;
  logic                  acc0;
  logic [ADDR_WIDTH-1:0] addr0;

  // N = min(num_row, ACCUM_ROW), compared at a width that holds both.
  logic [CMP_W-1:0] num_ext;
  logic [CNT_W-1:0] n_clamp;

  always_comb begin
    num_ext = CMP_W'(num_row);
    n_clamp = (num_ext > ROW_EXT) ? ROW_MAX : CNT_W'(num_row);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      n_lat    <= '0;
      base_lat <= '0;
      mode_lat <= 1'b0;
      en0      <= 1'b0;
      acc0     <= 1'b0;
      addr0    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_start) begin
            busy     <= 1'b1;
            base_lat <= base_addr;
            n_lat    <= n_clamp;
            mode_lat <= acc_mode;
            if (n_clamp == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (START_DELAY == 0) begin
              // No pipeline latency: the first write goes out immediately.
              state <= ISSUE;
              en0   <= 1'b1;
              acc0  <= acc_mode;
              addr0 <= base_addr;
              cnt   <= n_clamp - CNT_W'(1);
            end else begin
              state <= WAIT;
              cnt   <= D_M1;
            end
          end
        end

        WAIT: begin
          if (cnt == '0) begin
            state <= ISSUE;
            en0   <= 1'b1;
            acc0  <= mode_lat;
            addr0 <= base_lat;
            cnt   <= n_lat - CNT_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        // cnt holds the number of writes still to issue after the current one.
        ISSUE: begin
          if (cnt == '0) begin
            en0  <= 1'b0;
            acc0 <= 1'b0;
            if (SYS_COL == 1) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
              cnt   <= DRAIN_M1;
            end
          end else begin
            cnt   <= cnt - CNT_W'(1);
            addr0 <= addr0 + ADDR_WIDTH'(1);
          end
        end

        // Wait for the skew to carry the last write out to the final column.
        DRAIN: begin
          if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Skew chain: column j copies column j-1 one cycle later. The address of a
  // column only advances when the upstream column writes, so it holds its
  // last written value while idle.
  generate
    if (SYS_COL > 1) begin : g_skew
      logic [SYS_COL-1:1]    en_sk;
      logic [SYS_COL-1:1]    acc_sk;
      logic [ADDR_WIDTH-1:0] addr_sk [1:SYS_COL-1];

      always_ff @(posedge clk) begin
        if (!rstn) begin
          en_sk  <= '0;
          acc_sk <= '0;
          for (int j = 1; j < SYS_COL; j++) begin
            addr_sk[j] <= '0;
          end
        end else begin
          for (int j = 1; j < SYS_COL; j++) begin
            en_sk[j]  <= wr_en_out[j-1];
            acc_sk[j] <= wr_acc[j-1];
            if (wr_en_out[j-1]) begin
              addr_sk[j] <= wr_addr[j-1];
            end
          end
        end
      end

      assign wr_en_out  = {en_sk, en0};
      assign wr_acc     = {acc_sk, acc0};
      assign wr_addr[0] = addr0;

      for (genvar j = 1; j < SYS_COL; j++) begin : g_addr
        assign wr_addr[j] = addr_sk[j];
      end
    end else begin : g_single
      assign wr_en_out  = en0;
      assign wr_acc     = acc0;
      assign wr_addr[0] = addr0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wr_ctrl
//  Description : Directed self-checking bench for mem_wr_ctrl (default
//                parameters: 16 columns, 256 rows per bank, START_DELAY 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wr_ctrl;

  localparam int SC   = 16;
  localparam int D    = 2;
  localparam int MAXC = 300;

  logic        clk;
  logic        rstn;
  logic        wr_start;
  logic [15:0] num_row;
  logic [7:0]  base_addr;
  logic        acc_mode;
  logic [15:0] wr_en_out;
  logic [7:0]  wr_addr [0:SC-1];
  logic [15:0] wr_acc;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  // Per-cycle record of the outputs; index c holds the value seen in cycle c.
  logic [15:0] cap_en   [0:MAXC-1];
  logic [15:0] cap_acc  [0:MAXC-1];
  logic [7:0]  cap_addr [0:MAXC-1][0:SC-1];
  logic        cap_busy [0:MAXC-1];
  logic        cap_done [0:MAXC-1];

  mem_wr_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_start  (wr_start),
    .num_row   (num_row),
    .base_addr (base_addr),
    .acc_mode  (acc_mode),
    .wr_en_out (wr_en_out),
    .wr_addr   (wr_addr),
    .wr_acc    (wr_acc),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a start sampled at posedge 0 and record cycles 1..ncyc. Extra start
  // pulses land on posedges s1/s2/s3 and a reset on posedge rc (-1 = none).
  task automatic capture(input int n, input logic [7:0] base, input logic mode,
                         input int ncyc, input int s1, input int s2, input int s3,
                         input int rc);
    @(negedge clk);
    num_row   = n[15:0];
    base_addr = base;
    acc_mode  = mode;
    wr_start  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      cap_en[c]   = wr_en_out;
      cap_acc[c]  = wr_acc;
      cap_busy[c] = busy;
      cap_done[c] = done;
      for (int j = 0; j < SC; j++) cap_addr[c][j] = wr_addr[j];
      wr_start = (c == s1) || (c == s2) || (c == s3);
      rstn     = (c != rc);
    end
    @(negedge clk);
    wr_start = 1'b0;
    rstn     = 1'b1;
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    wr_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_en_out !== 16'h0) begin failures++; $display("FAIL reset_en: got %h required 0", wr_en_out); end
    checks++;
    if (wr_acc !== 16'h0) begin failures++; $display("FAIL reset_acc: got %h required 0", wr_acc); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
    for (int j = 0; j < SC; j++) begin
      checks++;
      if (wr_addr[j] !== 8'h00) begin
        failures++;
        $display("FAIL reset_addr[%0d]: got %h required 00", j, wr_addr[j]);
      end
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One complete operation: full write pattern, busy/done timing, optional
  // ignored starts (mid-run and in the done cycle) and a start right after done.
  task automatic test_run(input string name, input int n, input logic [7:0] base,
                          input logic mode, input int s1, input bit s_done, input bit s_after);
    int nn;
    int dc;
    int ncyc;
    nn   = (n > 256) ? 256 : n;
    dc   = (nn == 0) ? 1 : D + nn + SC;
    ncyc = s_after ? dc + 1 + D + 2 : dc + 1;
    capture(n, base, mode, ncyc, s1, s_done ? dc : -1, s_after ? dc + 1 : -1, -1);
    for (int c = 1; c <= dc + 1; c++) begin
      checks++;
      if (cap_busy[c] !== (c <= dc)) begin
        failures++;
        $display("FAIL %s busy cycle %0d: got %b required %b", name, c, cap_busy[c], (c <= dc));
      end
      checks++;
      if (cap_done[c] !== (c == dc)) begin
        failures++;
        $display("FAIL %s done cycle %0d: got %b required %b", name, c, cap_done[c], (c == dc));
      end
      for (int j = 0; j < SC; j++) begin
        int         t;
        logic [7:0] ea;
        logic       ee;
        ee = (nn > 0) && (c >= D + 1 + j) && (c <= D + nn + j);
        checks++;
        if (cap_en[c][j] !== ee) begin
          failures++;
          $display("FAIL %s en[%0d] cycle %0d: got %b required %b", name, j, c, cap_en[c][j], ee);
        end
        checks++;
        if (cap_acc[c][j] !== (ee & mode)) begin
          failures++;
          $display("FAIL %s acc[%0d] cycle %0d: got %b required %b", name, j, c, cap_acc[c][j], ee & mode);
        end
        if (ee || (nn > 0 && c > D + nn + j)) begin
          t  = ee ? base + (c - D - 1 - j) : base + nn - 1;
          ea = t[7:0];
          checks++;
          if (cap_addr[c][j] !== ea) begin
            failures++;
            $display("FAIL %s addr[%0d] cycle %0d: got %h required %h", name, j, c, cap_addr[c][j], ea);
          end
        end
      end
    end
    if (s_after) begin
      checks++;
      if (cap_busy[dc + 2] !== 1'b1) begin
        failures++;
        $display("FAIL %s restart_busy: got %b required 1", name, cap_busy[dc + 2]);
      end
      checks++;
      if (cap_en[dc + 2 + D][0] !== 1'b1 || cap_addr[dc + 2 + D][0] !== base) begin
        failures++;
        $display("FAIL %s restart_write: en=%b addr=%h required en=1 addr=%h", name,
                 cap_en[dc + 2 + D][0], cap_addr[dc + 2 + D][0], base);
      end
    end
  endtask

  // Accumulate run aborted by reset sampled at posedge 8.
  task automatic test_mid_reset();
    capture(4, 8'h40, 1'b1, 30, -1, -1, -1, 8);
    for (int c = 1; c <= 30; c++) begin
      for (int j = 0; j < SC; j++) begin
        logic ee;
        ee = (c <= 8) && (c >= D + 1 + j) && (c <= D + 4 + j);
        checks++;
        if (cap_en[c][j] !== ee || cap_acc[c][j] !== ee) begin
          failures++;
          $display("FAIL midrst en/acc[%0d] cycle %0d: got %b/%b required %b/%b", j, c,
                   cap_en[c][j], cap_acc[c][j], ee, ee);
        end
      end
      checks++;
      if (cap_busy[c] !== (c <= 8) || cap_done[c] !== 1'b0) begin
        failures++;
        $display("FAIL midrst busy/done cycle %0d: got %b/%b required %b/0", c,
                 cap_busy[c], cap_done[c], (c <= 8));
      end
    end
    for (int j = 0; j < SC; j++) begin
      checks++;
      if (cap_addr[9][j] !== 8'h00) begin
        failures++;
        $display("FAIL midrst addr[%0d] cycle 9: got %h required 00", j, cap_addr[9][j]);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rstn      = 1'b0;
    wr_start  = 1'b0;
    num_row   = 16'd0;
    base_addr = 8'h00;
    acc_mode  = 1'b0;

    test_reset();
    test_run("basic",      4,   8'h10, 1'b0, -1, 1'b0, 1'b0);
    test_run("wrap",       3,   8'hFE, 1'b0, -1, 1'b0, 1'b0);
    test_run("clamp",      300, 8'h00, 1'b0, -1, 1'b0, 1'b0);
    test_run("zero_rows",  0,   8'h55, 1'b1, -1, 1'b0, 1'b0);
    test_run("start_busy", 4,   8'h20, 1'b0, 5,  1'b1, 1'b1);
    test_mid_reset();
    test_run("acc_after_rst", 5, 8'h80, 1'b1, -1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
